// File: rtl/rng_pkg.sv
// Shared types and constants for the PRBS digit dispatcher.
package rng_pkg;

    localparam int DIGIT_W   = 4;
    localparam int DIGIT_MAX = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROLL,
        ST_SETTLE,
        ST_DONE
    } rng_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request after last_grant.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             valid
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the nearest requester after last_grant wins.
    always_comb begin
        grant_idx = '0;
        valid     = 1'b0;
        cand      = '0;
        for (int off = NREQ; off >= 1; off--) begin
            cand = IDX_W'((int'(last_grant) + off) % NREQ);
            if (req[cand]) begin
                grant_idx = cand;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rng_dispatch.sv
// Shares one PRBS digit generator among NREQ requesters: round-robin grant,
// roll pulse, settle wait, rejection sampling into 0..LIMIT, done strobe.
module rng_dispatch
    import rng_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int ROLL_W    = 1,
    parameter int SETTLE    = 2,
    parameter int LIMIT     = 9,
    parameter int MAX_RETRY = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    output logic [NREQ-1:0]          done,
    output logic [DIGIT_W-1:0]       digit,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  grant_idx,
    output logic                     rng_roll,
    output logic                     rng_en,
    input  logic [DIGIT_W-1:0]       rng_digit
);

    localparam int IDX_W   = $clog2(NREQ);
    localparam int TMR_MAX = (ROLL_W > SETTLE) ? ROLL_W : SETTLE;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TMR_W-1:0]   ROLL_LAST   = TMR_W'(ROLL_W - 1);
    localparam logic [TMR_W-1:0]   SETTLE_LAST = TMR_W'(SETTLE - 1);
    localparam logic [RTY_W-1:0]   RTY_LAST    = RTY_W'(MAX_RETRY);
    localparam logic [DIGIT_W-1:0] LIMIT_D     = DIGIT_W'(LIMIT);

    rng_state_t        state;
    logic [TMR_W-1:0]  tmr;
    logic [RTY_W-1:0]  retries;
    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_valid;
    logic [NREQ-1:0]   grant_onehot;

    // Unsigned acceptance test for a sampled generator digit.
    function automatic logic digit_ok(input logic [DIGIT_W-1:0] d);
        return d <= LIMIT_D;
    endfunction

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req        (req),
        .last_grant (last_grant),
        .grant_idx  (arb_idx),
        .valid      (arb_valid)
    );

    assign grant_onehot = NREQ'(1) << grant_idx;
    assign busy         = (state != ST_IDLE);

    // Transaction sequencer; every generator-facing output is a flop so roll is glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            tmr        <= '0;
            retries    <= '0;
            last_grant <= IDX_W'(NREQ - 1);
            grant_idx  <= '0;
            done       <= '0;
            digit      <= '0;
            rng_roll   <= 1'b0;
            rng_en     <= 1'b0;
        end else begin
            done <= '0;
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        grant_idx <= arb_idx;
                        retries   <= '0;
                        tmr       <= '0;
                        rng_roll  <= 1'b1;
                        rng_en    <= 1'b1;
                        state     <= ST_ROLL;
                    end
                end
                ST_ROLL: begin
                    if (tmr == ROLL_LAST) begin
                        tmr      <= '0;
                        rng_roll <= 1'b0;
                        state    <= ST_SETTLE;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (tmr == SETTLE_LAST) begin
                        tmr <= '0;
                        if (digit_ok(rng_digit)) begin
                            digit  <= rng_digit;
                            done   <= grant_onehot;
                            rng_en <= 1'b0;
                            state  <= ST_DONE;
                        end else if (retries != RTY_LAST) begin
                            retries  <= retries + RTY_W'(1);
                            rng_roll <= 1'b1;
                            state    <= ST_ROLL;
                        end else begin
                            // Out of re-rolls: force the largest legal value.
                            digit  <= LIMIT_D;
                            done   <= grant_onehot;
                            rng_en <= 1'b0;
                            state  <= ST_DONE;
                        end
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                ST_DONE: begin
                    last_grant <= grant_idx;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
